// File: rtl/sal_axi_r_responder_pkg.sv
// Shared types and constants for the AXI read-response path.
//
// Contents:
//   AXI_ID_WIDTH / AXI_LEN_WIDTH : ID and burst-length widths, also used by
//                                  the AR acceptance logic
//   RRESP_OKAY                   : the only response this path returns
//   rd_req_t                     : one queued read request {id, len}
//   r_state_e                    : read-response sequencer states
package sal_axi_r_responder_pkg;

  localparam int AXI_ID_WIDTH  = 4;
  localparam int AXI_LEN_WIDTH = 8;

  localparam logic [1:0] RRESP_OKAY = 2'b00;

  // len holds arlen, i.e. beats-1
  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]  id;
    logic [AXI_LEN_WIDTH-1:0] len;
  } rd_req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } r_state_e;

endpackage

// File: rtl/sal_axi_r_responder_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered storage.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and payload
//   pop        : consume the head entry (ignored when empty)
//   dout       : head entry, valid whenever !empty
//   count      : number of stored entries (0..DEPTH)
//   full/empty : occupancy flags
//
// A push while full is accepted only if a pop happens in the same cycle.
// The head is read straight out of the storage array, so an entry written in
// cycle N is visible on dout in cycle N+1.
module sal_axi_r_responder_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // When full, the slot being written is the one being popped this cycle.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  // Pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sal_axi_r_responder.sv
// AXI read-response channel of the DDR controller's slave port.
//
// Queues accepted AR requests and the in-order read beats coming back from
// the DFI read path, then replays them on the AXI R channel under rready
// backpressure, one burst per request in request order.
//
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   req_valid/req_ready       : accepted AR request push {req_id, req_len}
//   rd_data_valid, rd_data    : read beat from the DFI path (no backpressure)
//   data_free                 : registered free entries of the data FIFO
//   overflow                  : sticky, a beat arrived with the data FIFO full
//   rid/rdata/rresp/rlast     : AXI R payload
//   rvalid/rready             : AXI R handshake
module sal_axi_r_responder
  import sal_axi_r_responder_pkg::*;
#(
  parameter int ID_WIDTH   = AXI_ID_WIDTH,
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = AXI_LEN_WIDTH,
  parameter int REQ_DEPTH  = 4,
  parameter int DATA_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ID_WIDTH-1:0]           req_id,
  input  logic [LEN_WIDTH-1:0]          req_len,
  input  logic                          rd_data_valid,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  output logic [$clog2(DATA_DEPTH):0]   data_free,
  output logic                          overflow,
  output logic [ID_WIDTH-1:0]           rid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [1:0]                    rresp,
  output logic                          rlast,
  output logic                          rvalid,
  input  logic                          rready
);

  localparam int FW  = $clog2(DATA_DEPTH) + 1;
  localparam int RCW = $clog2(REQ_DEPTH) + 1;

  r_state_e              state_q, state_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  overflow_q, overflow_d;
  logic [FW-1:0]         data_free_q, data_free_d;

  rd_req_t               req_in, req_head;
  logic                  req_full, req_empty, req_push, req_pop;
  logic [RCW-1:0]        req_count;

  logic [DATA_WIDTH-1:0] data_head;
  logic                  data_full, data_empty, data_pop, data_push_acc;
  logic [FW-1:0]         data_count;

  logic                  handshake;

  // No bypass: a full request FIFO refuses even when it pops this cycle.
  assign req_ready = !req_full;
  assign req_push  = req_valid && !req_full;
  assign req_in.id  = req_id;
  assign req_in.len = req_len;

  assign handshake = rvalid && rready;
  assign data_pop  = handshake;
  assign req_pop   = handshake && rlast;

  // Mirrors the FIFO's own acceptance rule: full is fine if a beat leaves.
  assign data_push_acc = rd_data_valid && (!data_full || data_pop);

  assign overflow  = overflow_q;
  assign data_free = data_free_q;

  sal_axi_r_responder_sync_fifo #(
    .WIDTH ($bits(rd_req_t)),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_push),
    .din   (req_in),
    .pop   (req_pop),
    .dout  (req_head),
    .count (req_count),
    .full  (req_full),
    .empty (req_empty)
  );

  sal_axi_r_responder_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DATA_DEPTH)
  ) u_data_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_data_valid),
    .din   (rd_data),
    .pop   (data_pop),
    .dout  (data_head),
    .count (data_count),
    .full  (data_full),
    .empty (data_empty)
  );

  // State and beat counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next state. A request pushed this cycle counts as queued, so the first
  // burst starts the cycle after its push and consecutive bursts never bubble.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (!req_empty || req_push) state_d = BURST;
      end
      BURST: begin
        if (handshake) begin
          if (rlast) begin
            beat_cnt_d = '0;
            if (!(req_count > RCW'(1)) && !req_push) state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // R channel outputs. Everything is derived from FIFO heads and beat_cnt,
  // none of which change while a beat is stalled, so the payload holds.
  always_comb begin
    rvalid = 1'b0;
    rid    = '0;
    rdata  = '0;
    rresp  = RRESP_OKAY;
    rlast  = 1'b0;
    case (state_q)
      BURST: begin
        rvalid = !data_empty;
        rid    = req_head.id;
        rdata  = data_head;
        rlast  = (beat_cnt_q == req_head.len);
      end
      default: begin
        rvalid = 1'b0;
      end
    endcase
  end

  // Free-space credit after this cycle's push/pop, and sticky overflow
  always_comb begin
    data_free_d = FW'(DATA_DEPTH) - data_count - FW'(data_push_acc) + FW'(data_pop);
    overflow_d  = overflow_q || (rd_data_valid && data_full && !data_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_free_q <= FW'(DATA_DEPTH);
      overflow_q  <= 1'b0;
    end else begin
      data_free_q <= data_free_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule
